// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of the single data memory. Port 0 is preferred from idle,
// and a busy owner is pre-empted after MAX_BURST grants. Build with DMEM_ARB_STATS_EN for grant/conflict counters.
module dmem_arbiter #(
   parameter int AW        = 32,
   parameter int DW        = 32,
   parameter int MAX_BURST = 4
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          m0_req,
   input  logic          m0_we,
   input  logic [AW-1:0] m0_addr,
   input  logic [DW-1:0] m0_wdata,
   output logic          m0_gnt,
   output logic          m0_rvalid,
   output logic [DW-1:0] m0_rdata,
   input  logic          m1_req,
   input  logic          m1_we,
   input  logic [AW-1:0] m1_addr,
   input  logic [DW-1:0] m1_wdata,
   output logic          m1_gnt,
   output logic          m1_rvalid,
   output logic [DW-1:0] m1_rdata,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   input  logic [DW-1:0] mem_rdata
`ifdef DMEM_ARB_STATS_EN
   ,
   output logic [15:0]   stat_gnt0,
   output logic [15:0]   stat_gnt1,
   output logic [15:0]   stat_conflict
`endif
);

   typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

   localparam logic [3:0] MAXB = 4'(MAX_BURST);

   state_t     state;
   logic [3:0] burst_cnt;
   logic       rd_pend;
   logic       rd_port;
   logic       g0, g1;

   // Grant is decided in the request cycle; everything is gated while reset is low.
   always_comb begin
      g0 = 1'b0;
      g1 = 1'b0;
      if (reset) begin
         if (m0_req && m1_req) begin
            unique case (state)
               OWN0:    g0 = (burst_cnt < MAXB);
               OWN1:    g0 = (burst_cnt >= MAXB);
               default: g0 = 1'b1;
            endcase
            g1 = ~g0;
         end else begin
            g0 = m0_req;
            g1 = m1_req;
         end
      end
   end

   assign m0_gnt    = g0;
   assign m1_gnt    = g1;
   assign mem_we    = (g0 & m0_we) | (g1 & m1_we);
   assign mem_addr  = !reset ? '0 : (g1 ? m1_addr  : m0_addr);
   assign mem_wdata = !reset ? '0 : (g1 ? m1_wdata : m0_wdata);

   // Memory read data is registered, so the response lines follow one cycle behind the grant.
   assign m0_rvalid = reset & rd_pend & ~rd_port;
   assign m1_rvalid = reset & rd_pend &  rd_port;
   assign m0_rdata  = m0_rvalid ? mem_rdata : '0;
   assign m1_rdata  = m1_rvalid ? mem_rdata : '0;

   always_ff @(posedge clk) begin
      if (!reset) begin
         state     <= IDLE;
         burst_cnt <= 4'd0;
         rd_pend   <= 1'b0;
         rd_port   <= 1'b0;
      end else begin
         rd_pend <= (g0 & ~m0_we) | (g1 & ~m1_we);
         rd_port <= g1;
         if (g0) begin
            if (state == OWN0) begin
               if (burst_cnt < MAXB) burst_cnt <= burst_cnt + 4'd1;
            end else begin
               state     <= OWN0;
               burst_cnt <= 4'd1;
            end
         end else if (g1) begin
            if (state == OWN1) begin
               if (burst_cnt < MAXB) burst_cnt <= burst_cnt + 4'd1;
            end else begin
               state     <= OWN1;
               burst_cnt <= 4'd1;
            end
         end else begin
            state     <= IDLE;
            burst_cnt <= 4'd0;
         end
      end
   end

`ifdef DMEM_ARB_STATS_EN
   always_ff @(posedge clk) begin
      if (!reset) begin
         stat_gnt0     <= 16'd0;
         stat_gnt1     <= 16'd0;
         stat_conflict <= 16'd0;
      end else begin
         if (g0 && stat_gnt0 != 16'hFFFF) stat_gnt0 <= stat_gnt0 + 16'd1;
         if (g1 && stat_gnt1 != 16'hFFFF) stat_gnt1 <= stat_gnt1 + 16'd1;
         if (m0_req && m1_req && stat_conflict != 16'hFFFF)
            stat_conflict <= stat_conflict + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Randomized bench for dmem_arbiter: a transaction-level model predicts grants,
// memory strobes and read returns; a small registered memory sits behind the DUT.
module tb_dmem_arbiter;

   localparam int MAXB = 4;

   logic        clk = 1'b0;
   logic        reset;
   logic        m0_req, m0_we, m1_req, m1_we;
   logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
   logic        m0_gnt, m0_rvalid, m1_gnt, m1_rvalid;
   logic [31:0] m0_rdata, m1_rdata;
   logic        mem_we;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;
`ifdef DMEM_ARB_STATS_EN
   logic [15:0] stat_gnt0, stat_gnt1, stat_conflict;
`endif

   int n_tests = 0;
   int n_fail  = 0;

   logic [31:0] mem     [256];
   logic [31:0] ref_mem [256];

   // model state: last owner (-1 = none), run length, pending read return
   int          owner = -1;
   int          run   = 0;
   int          pend  = -1;
   logic [31:0] pend_data;
   int          gseq[$];
   int          n_g0 = 0, n_g1 = 0, n_conf = 0;

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (mem_we) mem[mem_addr[7:0]] <= mem_wdata;
      mem_rdata <= mem[mem_addr[7:0]];
   end

   dmem_arbiter #(.AW(32), .DW(32), .MAX_BURST(MAXB)) dut (
      .clk(clk), .reset(reset),
      .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
      .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
      .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
      .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
      .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
`ifdef DMEM_ARB_STATS_EN
      , .stat_gnt0(stat_gnt0), .stat_gnt1(stat_gnt1), .stat_conflict(stat_conflict)
`endif
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic arm(input int p, input logic we, input logic [31:0] a, input logic [31:0] d);
      if (p == 0) begin m0_req = 1; m0_we = we; m0_addr = a; m0_wdata = d; end
      else        begin m1_req = 1; m1_we = we; m1_addr = a; m1_wdata = d; end
   endtask

   // One clock: predict, compare mid-cycle, advance the model, retire the granted request.
   task automatic step(input logic rst);
      int g, obs_g;
      logic        gw;
      logic [31:0] ga, gd;
      reset = rst;
      #1;
      g = -1;
      if (rst) begin
         if (m0_req && !m1_req)      g = 0;
         else if (m1_req && !m0_req) g = 1;
         else if (m0_req && m1_req)  g = (owner < 0) ? 0 : ((run < MAXB) ? owner : 1 - owner);
      end
      gw = (g == 1) ? m1_we    : m0_we;
      ga = (g == 1) ? m1_addr  : m0_addr;
      gd = (g == 1) ? m1_wdata : m0_wdata;
      chk("gnt0", {31'd0, m0_gnt}, {31'd0, g == 0});
      chk("gnt1", {31'd0, m1_gnt}, {31'd0, g == 1});
      chk("rvalid0", {31'd0, m0_rvalid}, {31'd0, rst && pend == 0});
      chk("rvalid1", {31'd0, m1_rvalid}, {31'd0, rst && pend == 1});
      chk("rdata0", m0_rdata, (rst && pend == 0) ? pend_data : 32'd0);
      chk("rdata1", m1_rdata, (rst && pend == 1) ? pend_data : 32'd0);
      if (!rst) begin
         chk("rst_we", {31'd0, mem_we}, 32'd0);
         chk("rst_addr", mem_addr, 32'd0);
         chk("rst_wdata", mem_wdata, 32'd0);
      end else if (g >= 0) begin
         chk("mem_we", {31'd0, mem_we}, {31'd0, gw});
         chk("mem_addr", mem_addr, ga);
         if (gw) chk("mem_wdata", mem_wdata, gd);
      end else begin
         chk("idle_we", {31'd0, mem_we}, 32'd0);
         chk("idle_addr", mem_addr, m0_addr);
      end
      obs_g = m0_gnt ? 0 : (m1_gnt ? 1 : -1);
      if (obs_g >= 0) gseq.push_back(obs_g);
      if (!rst) begin
         owner = -1; run = 0; pend = -1;
         n_g0 = 0; n_g1 = 0; n_conf = 0;
      end else begin
         if (m0_req && m1_req) n_conf++;
         pend = -1;
         if (g >= 0) begin
            if (g == 0) n_g0++; else n_g1++;
            if (gw) ref_mem[ga[7:0]] = gd;
            else begin pend = g; pend_data = ref_mem[ga[7:0]]; end
            if (g == owner) run = (run < MAXB) ? run + 1 : MAXB;
            else begin owner = g; run = 1; end
         end else begin
            owner = -1; run = 0;
         end
      end
      @(posedge clk); #1;
      if (g == 0) m0_req = 0;
      if (g == 1) m1_req = 0;
   endtask

   initial begin
      int exp_seq[9];
      exp_seq = '{0, 0, 0, 0, 1, 1, 1, 1, 0};
      for (int i = 0; i < 256; i++) begin
         mem[i] = $urandom;
         ref_mem[i] = mem[i];
      end
      mem[8'h40] = 32'hDEADBEEF; ref_mem[8'h40] = 32'hDEADBEEF;
      m0_req = 0; m0_we = 0; m0_addr = 0; m0_wdata = 0;
      m1_req = 0; m1_we = 0; m1_addr = 0; m1_wdata = 0;
      reset = 0;
      @(posedge clk); #1;

      // reset held with both requesting: nothing granted, then port 0 wins first
      arm(0, 0, 32'h10, 0); arm(1, 0, 32'h14, 0);
      step(0); step(0);
      chk("first_gnt_cnt", gseq.size(), 0);
      step(1);
      chk("first_gnt", gseq[0], 0);
      m0_req = 0; m1_req = 0;
      step(1); step(1);

      // single read on port 0
      arm(0, 0, 32'h40, 0);
      step(1); step(1);

      // write then read on port 1
      arm(1, 1, 32'h80, 32'h12345678);
      step(1);
      arm(1, 0, 32'h80, 0);
      step(1); step(1);
      chk("raw_mem", ref_mem[8'h80], 32'h12345678);

      // bounded burst from idle with both ports always requesting
      step(1);
      gseq.delete();
      for (int i = 0; i < 9; i++) begin
         if (!m0_req) arm(0, 0, 32'(4 * $urandom_range(0, 15)), 0);
         if (!m1_req) arm(1, 0, 32'(4 * $urandom_range(0, 15)), 0);
         step(1);
      end
      for (int i = 0; i < 9; i++) chk("burst_seq", gseq[i], exp_seq[i]);
      m0_req = 0; m1_req = 0;
      step(1);

      // reset lands in the cycle of a read return
      arm(0, 0, 32'h40, 0);
      step(1);
      step(0);
      step(1); step(1);

      // randomized traffic
      for (int c = 0; c < 1500; c++) begin
         if (!m0_req) begin
            if ($urandom_range(0, 9) < 6)
               arm(0, 1'($urandom_range(0, 1)), 32'(4 * $urandom_range(0, 15)), $urandom);
         end else if ($urandom_range(0, 15) == 0) m0_req = 0;
         if (!m1_req) begin
            if ($urandom_range(0, 9) < 6)
               arm(1, 1'($urandom_range(0, 1)), 32'(4 * $urandom_range(0, 15)), $urandom);
         end else if ($urandom_range(0, 15) == 0) m1_req = 0;
         step(($urandom_range(0, 199) == 0) ? 1'b0 : 1'b1);
`ifdef DMEM_ARB_STATS_EN
         chk("stat_gnt0", {16'd0, stat_gnt0}, 32'(n_g0));
         chk("stat_gnt1", {16'd0, stat_gnt1}, 32'(n_g1));
         chk("stat_conflict", {16'd0, stat_conflict}, 32'(n_conf));
`endif
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
